// File: rtl/rns_ct_addsub_engine.sv
// Streaming RNS add/sub engine: one command, then poly0 and poly1 beats of LANES residues.
// Define RNS_ADDSUB_RANGE_CHECK_EN to build the sticky operand range checker (range_err).
module rns_ct_addsub_engine #(
    parameter int unsigned W       = 32,
    parameter int unsigned NCOEFF  = 4,
    parameter int unsigned NPRIMES = 2,
    parameter int unsigned LANES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPRIMES*W-1:0] moduli,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_x,
    input  logic [LANES*W-1:0]   in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_z,
    output logic                 out_poly,
    output logic                 out_last,
    output logic                 done,
    output logic                 range_err
);
    localparam int unsigned NBEAT = NCOEFF * NPRIMES / LANES;
    localparam int unsigned CW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CW-1:0] LastBeat = CW'(NBEAT - 1);
    localparam logic [1:0] ModeSub = 2'd1;
    localparam logic [1:0] ModePt  = 2'd2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t             state;
    logic [1:0]         mode;
    logic [CW-1:0]      beat_cnt;
    logic               in_poly;
    logic               in_fire;
    logic               last_beat;
    logic               pt_pass;
    logic [LANES*W-1:0] z_next;

    assign cmd_ready = (state == StIdle);
    assign in_ready  = (state == StRun) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign last_beat = (beat_cnt == LastBeat);
    // CT-PT poly0 passes the ciphertext through untouched
    assign pt_pass   = (mode == ModePt) && !in_poly;
    assign done      = (state == StDrain) && out_valid && out_ready;

`ifdef RNS_ADDSUB_RANGE_CHECK_EN
    logic [LANES-1:0] lane_err;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int unsigned P = l % NPRIMES;
        logic [W-1:0] x, y, q, z;
        logic [W:0]   sum;

        assign x   = in_x[l*W +: W];
        assign y   = in_y[l*W +: W];
        assign q   = moduli[P*W +: W];
        assign sum = {1'b0, x} + {1'b0, y};

        always_comb begin
            if (pt_pass) begin
                z = x;
            end else if (mode == ModeSub) begin
                z = (x < y) ? x - y + q : x - y;
            end else begin
                z = (sum >= {1'b0, q}) ? W'(sum - {1'b0, q}) : sum[W-1:0];
            end
        end

        assign z_next[l*W +: W] = z;
`ifdef RNS_ADDSUB_RANGE_CHECK_EN
        assign lane_err[l] = (x >= q) || (!pt_pass && (y >= q));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            mode      <= 2'd0;
            beat_cnt  <= '0;
            in_poly   <= 1'b0;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_poly  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        state    <= StRun;
                        mode     <= cmd_mode;
                        beat_cnt <= '0;
                        in_poly  <= 1'b0;
                    end
                end
                StRun: begin
                    if (in_fire) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            in_poly  <= ~in_poly;
                            if (in_poly) state <= StDrain;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_valid && out_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase

            if (in_fire) begin
                out_valid <= 1'b1;
                out_z     <= z_next;
                out_poly  <= in_poly;
                out_last  <= last_beat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RNS_ADDSUB_RANGE_CHECK_EN
    logic range_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_q <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            range_q <= 1'b0;
        end else if (in_fire && (|lane_err)) begin
            range_q <= 1'b1;
        end
    end

    assign range_err = range_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_rns_ct_addsub_engine.sv
// Directed bench for rns_ct_addsub_engine with W=8, q0=17, q1=13, two lanes, four beats per poly.
module tb_rns_ct_addsub_engine;
    localparam int W = 8;
    localparam int NCOEFF = 4;
    localparam int NPRIMES = 2;
    localparam int LANES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] moduli = {8'd13, 8'd17};
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_z;
    logic        out_poly;
    logic        out_last;
    logic        done;
    logic        range_err;

    rns_ct_addsub_engine #(
        .W(W), .NCOEFF(NCOEFF), .NPRIMES(NPRIMES), .LANES(LANES)
    ) dut (
        .clk(clk), .reset(reset), .moduli(moduli),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_poly(out_poly), .out_last(out_last), .done(done), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] cap_z[8];
    logic        cap_poly[8];
    logic        cap_last[8];
    int ncap, done_cnt, stall_err, cmd_wait;

    // Drives one full command and records every handshaken output beat.
    task automatic run_op(input logic [1:0] mode, input logic [15:0] xa, input logic [15:0] ya,
                          input logic [15:0] xb, input logic [15:0] yb, input bit bp);
        int sent = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit fin = 1'b0;
        logic [17:0] held = '0;
        ncap = 0; done_cnt = 0; stall_err = 0; cmd_wait = 0;
        @(negedge clk);
        while (!cmd_ready && cmd_wait < 20) begin
            @(negedge clk);
            cmd_wait++;
        end
        cmd_valid = 1'b1;
        cmd_mode = mode;
        @(posedge clk);
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            out_ready = bp ? (cyc % 2 == 0) : 1'b1;
            in_valid = (sent < 8) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_x = (sent < 4) ? xa : xb;
            in_y = (sent < 4) ? ya : yb;
            #1;
            if (stalled && ({out_z, out_poly, out_last} !== held)) stall_err++;
            stalled = out_valid && !out_ready;
            held = {out_z, out_poly, out_last};
            if (out_valid && out_ready) begin
                if (ncap < 8) begin
                    cap_z[ncap] = out_z;
                    cap_poly[ncap] = out_poly;
                    cap_last[ncap] = out_last;
                end
                ncap++;
            end
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (out_z !== 16'h0) begin nerr++; $display("FAIL reset_out_z got %h want 0", out_z); end
        nvec++; if ({out_poly, out_last, done, range_err} !== 4'b0) begin
            nerr++; $display("FAIL reset_flags got %b want 0000", {out_poly, out_last, done, range_err});
        end
    endtask

    task automatic test_add();
        run_op(2'd0, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd10, 8'd10}, {8'd3, 8'd3}, 1'b0);
        nvec++; if (ncap !== 8) begin nerr++; $display("FAIL add_count got %0d want 8", ncap); end
        nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL add_done got %0d want 1", done_cnt); end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if ({cap_z[i], cap_poly[i], cap_last[i]} !==
                {(i < 4) ? {8'd12, 8'd12} : {8'd0, 8'd13}, i >= 4, i == 3 || i == 7}) begin
                nerr++;
                $display("FAIL add_beat[%0d] got z=%h poly=%b last=%b", i, cap_z[i], cap_poly[i],
                         cap_last[i]);
            end
        end
    endtask

    task automatic test_sub();
        run_op(2'd1, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd9, 8'd9}, {8'd9, 8'd9}, 1'b0);
        nvec++; if (done_cnt !== 1 || ncap !== 8) begin
            nerr++; $display("FAIL sub_done got done=%0d beats=%0d want 1/8", done_cnt, ncap);
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (cap_z[i] !== ((i < 4) ? {8'd11, 8'd15} : 16'h0)) begin
                nerr++; $display("FAIL sub_z[%0d] got %h want %h", i, cap_z[i],
                                 (i < 4) ? {8'd11, 8'd15} : 16'h0);
            end
        end
    endtask

    task automatic test_pt_add();
        run_op(2'd2, {8'd5, 8'd5}, {8'd4, 8'd4}, {8'd10, 8'd10}, {8'd4, 8'd4}, 1'b0);
        nvec++; if (done_cnt !== 1 || ncap !== 8) begin
            nerr++; $display("FAIL pt_done got done=%0d beats=%0d want 1/8", done_cnt, ncap);
        end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if ({cap_z[i], cap_poly[i], cap_last[i]} !==
                {(i < 4) ? {8'd5, 8'd5} : {8'd1, 8'd14}, i >= 4, i == 3 || i == 7}) begin
                nerr++;
                $display("FAIL pt_beat[%0d] got z=%h poly=%b last=%b", i, cap_z[i], cap_poly[i],
                         cap_last[i]);
            end
        end
    endtask

    task automatic test_mode3();
        run_op(2'd3, {8'd12, 8'd16}, {8'd12, 8'd16}, 16'h0, 16'h0, 1'b0);
        nvec++; if (cap_z[0] !== {8'd11, 8'd15}) begin
            nerr++; $display("FAIL mode3_a got %h want 0b0f", cap_z[0]);
        end
        nvec++; if (cap_z[7] !== 16'h0) begin nerr++; $display("FAIL mode3_b got %h want 0", cap_z[7]); end
    endtask

    task automatic test_backpressure();
        run_op(2'd0, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd10, 8'd10}, {8'd3, 8'd3}, 1'b1);
        nvec++; if (ncap !== 8) begin nerr++; $display("FAIL bp_count got %0d want 8", ncap); end
        nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL bp_done got %0d want 1", done_cnt); end
        nvec++; if (stall_err !== 0) begin nerr++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if ({cap_z[i], cap_poly[i], cap_last[i]} !==
                {(i < 4) ? {8'd12, 8'd12} : {8'd0, 8'd13}, i >= 4, i == 3 || i == 7}) begin
                nerr++;
                $display("FAIL bp_beat[%0d] got z=%h poly=%b last=%b", i, cap_z[i], cap_poly[i],
                         cap_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'd0, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd10, 8'd10}, {8'd3, 8'd3}, 1'b0);
        run_op(2'd1, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd9, 8'd9}, {8'd9, 8'd9}, 1'b0);
        nvec++; if (cmd_wait !== 0) begin nerr++; $display("FAIL b2b_accept got wait=%0d want 0", cmd_wait); end
        nvec++; if (cap_z[0] !== {8'd11, 8'd15} || done_cnt !== 1) begin
            nerr++; $display("FAIL b2b_result got %h done=%0d want 0b0f done=1", cap_z[0], done_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int dcount = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_x = {8'd5, 8'd5};
        in_y = {8'd7, 8'd7};
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        nvec++; if ({cmd_ready, in_ready, out_valid} !== 3'b100) begin
            nerr++; $display("FAIL midrst_hs got %b want 100", {cmd_ready, in_ready, out_valid});
        end
        nvec++; if ({out_z, out_poly, out_last, done, range_err} !== 20'h0) begin
            nerr++; $display("FAIL midrst_out got z=%h flags=%b want 0", out_z,
                             {out_poly, out_last, done, range_err});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done) dcount++;
        end
        nvec++; if (dcount !== 0) begin nerr++; $display("FAIL midrst_nodone got %0d want 0", dcount); end
        run_op(2'd0, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd10, 8'd10}, {8'd3, 8'd3}, 1'b0);
        nvec++; if (ncap !== 8 || done_cnt !== 1 || cap_z[7] !== {8'd0, 8'd13}) begin
            nerr++; $display("FAIL midrst_rerun got beats=%0d done=%0d z=%h want 8/1/000d", ncap,
                             done_cnt, cap_z[7]);
        end
    endtask

    task automatic test_range();
        logic exp_err;
`ifdef RNS_ADDSUB_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_op(2'd0, {8'd5, 8'd20}, {8'd7, 8'd7}, {8'd10, 8'd10}, {8'd3, 8'd3}, 1'b0);
        #1;
        nvec++; if (range_err !== exp_err) begin
            nerr++; $display("FAIL range_set got %b want %b", range_err, exp_err);
        end
        run_op(2'd0, {8'd5, 8'd5}, {8'd7, 8'd7}, {8'd10, 8'd10}, {8'd3, 8'd3}, 1'b0);
        #1;
        nvec++; if (range_err !== 1'b0) begin nerr++; $display("FAIL range_clear got %b want 0", range_err); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_add();
        test_sub();
        test_pt_add();
        test_mode3();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
